// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, column count and key map for the 4x4 keypad scanner.
package keypad_pkg;
  localparam int NUM_COLS = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_DEBOUNCE, ST_PRESSED, ST_RELEASE} state_e;
  typedef enum logic [1:0] {SC_NONE, SC_SINGLE, SC_MULTI} scan_class_e;
  // Nibble n is the code for snapshot bit n (row*4+col); '*' maps to E, '#' to F.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [3:0] key_map(input logic [3:0] pos);
    return KEY_MAP[pos*4 +: 4];
  endfunction
endpackage

// File: rtl/row_sync.sv
// row_sync: two-flop synchronizer for the asynchronous keypad rows, resetting to released.
module row_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);
  logic [3:0] meta_q, sync_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end
  assign q_o = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: column-scans a 4x4 keypad, debounces across whole scans and
// emits one key code per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d, snap_cur;
  state_e        state_q, state_d;
  logic [3:0]    cand_q, cand_d, code_q, code_d, pos;
  logic [CW-1:0] cnt_q, cnt_d, rcnt_q, rcnt_d;
  logic          valid_q, valid_d, held_q, held_d;
  logic [3:0]    row_s;
  logic [1:0]    n_set;
  scan_class_e   cls;
  logic          sample, scan_end;

  row_sync u_sync (.clk(clk), .reset(reset), .d_i(row), .q_o(row_s));

  assign sample   = div_q == DIV_LAST;
  assign scan_end = sample && idx_q == 2'(NUM_COLS - 1);

  always_comb begin
    snap_cur = snap_q;
    if (sample)
      for (int r = 0; r < 4; r++) snap_cur[{2'(r), idx_q}] = ~row_s[r];
  end

  // n_set saturates at 2: only none/one/many matters.
  always_comb begin
    n_set = '0;
    pos   = '0;
    for (int i = 0; i < 16; i++)
      if (snap_cur[i]) begin
        n_set = n_set == 2'd2 ? 2'd2 : n_set + 2'd1;
        pos   = 4'(i);
      end
    cls = n_set == 2'd0 ? SC_NONE : n_set == 2'd1 ? SC_SINGLE : SC_MULTI;
  end

  assign div_d  = sample ? '0 : div_q + DW'(1);
  assign idx_d  = sample ? idx_q + 2'd1 : idx_q;
  assign snap_d = scan_end ? '0 : snap_cur;

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    rcnt_d  = rcnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (scan_end)
      case (state_q)
        ST_IDLE:
          if (cls == SC_SINGLE) begin
            cand_d  = pos;
            cnt_d   = CW'(1);
            state_d = ST_DEBOUNCE;
          end
        ST_DEBOUNCE:
          if (cls != SC_SINGLE) state_d = ST_IDLE;
          else if (pos != cand_q) begin
            cand_d = pos;
            cnt_d  = CW'(1);
          end else if (cnt_q == CNT_LAST) begin
            code_d  = key_map(cand_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
            state_d = ST_PRESSED;
          end else cnt_d = cnt_q + CW'(1);
        ST_PRESSED:
          if (cls == SC_NONE) begin
            rcnt_d  = CW'(1);
            state_d = ST_RELEASE;
          end
        default:
          if (cls != SC_NONE) begin
            rcnt_d  = '0;
            state_d = ST_PRESSED;
          end else if (rcnt_q == CNT_LAST) begin
            held_d  = 1'b0;
            state_d = ST_IDLE;
          end else rcnt_d = rcnt_q + CW'(1);
      endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q   <= '0;
      idx_q   <= '0;
      snap_q  <= '0;
      state_q <= ST_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
      rcnt_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      div_q   <= div_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      rcnt_q  <= rcnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign col       = ~(4'b0001 << idx_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule
